// File: rtl/fetcher_pkg.sv
// fetcher_pkg: shared widths and address helpers for the instruction fetch unit.
package fetcher_pkg;
  localparam int XLEN = 32;
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetcher_icache.sv
// fetcher_icache: direct-mapped one-word-per-line instruction cache (used by fetcher under ICACHE_EN).
module fetcher_icache
  import fetcher_pkg::*;
#(
  parameter int LINES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] i_addr,
  output logic            o_hit,
  output logic [XLEN-1:0] o_data,
  input  logic            i_we,
  input  logic [XLEN-1:0] i_waddr,
  input  logic [XLEN-1:0] i_wdata
);
  localparam int IW = $clog2(LINES);
  localparam int TW = XLEN - IW - 2;
  logic [LINES-1:0] r_valid;
  logic [XLEN-1:0]  r_data [LINES];
  logic [TW-1:0]    r_tag  [LINES];
  logic [IW-1:0]    w_idx, w_widx;
  assign w_idx  = i_addr[IW+1:2];
  assign w_widx = i_waddr[IW+1:2];
  assign o_hit  = r_valid[w_idx] && r_tag[w_idx] == i_addr[XLEN-1:IW+2];
  assign o_data = r_data[w_idx];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_valid <= '0;
    else if (i_we) r_valid[w_widx] <= 1'b1;
  end
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_data[w_widx] <= i_wdata;
      r_tag[w_widx]  <= i_waddr[XLEN-1:IW+2];
    end
  end
endmodule

// File: rtl/fetcher.sv
// fetcher: RV32I instruction fetch unit with one-cycle offers, flush redirect and response discard.
// Optional direct-mapped instruction cache enabled by defining ICACHE_EN.
module fetcher
  import fetcher_pkg::*;
#(
  parameter int ICACHE_LINES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  output logic            instr_ready,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] instr_addr_out,
  input  logic            instr_issued,
  input  logic [XLEN-1:0] predict_pc,
  input  logic            rob_clear,
  input  logic [XLEN-1:0] rob_clear_pc,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_data
);
  localparam logic [2:0] S_FETCH      = 3'd0;
  localparam logic [2:0] S_MEM_WAIT   = 3'd1;
  localparam logic [2:0] S_OFFER      = 3'd2;
  localparam logic [2:0] S_WAIT_ISSUE = 3'd3;
  localparam logic [2:0] S_DISCARD    = 3'd4;
  logic [2:0]      r_state;
  logic [XLEN-1:0] r_pc;
  logic            w_hit, w_fill, w_pending;
  logic [XLEN-1:0] w_cdata;
  assign w_fill    = rdy && !rob_clear && r_state == S_MEM_WAIT && mem_ready;
  // a flush only has to wait out a request whose response has not yet arrived
  assign w_pending = (r_state == S_MEM_WAIT || r_state == S_DISCARD) && !mem_ready;
`ifdef ICACHE_EN
  fetcher_icache #(.LINES(ICACHE_LINES)) u_icache (
    .clk    (clk),
    .rst    (rst),
    .i_addr (r_pc),
    .o_hit  (w_hit),
    .o_data (w_cdata),
    .i_we   (w_fill),
    .i_waddr(r_pc),
    .i_wdata(mem_data)
  );
`else
  assign w_hit   = 1'b0;
  assign w_cdata = '0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_FETCH;
      r_pc           <= '0;
      instr_ready    <= 1'b0;
      instr_out      <= '0;
      instr_addr_out <= '0;
      mem_req        <= 1'b0;
      mem_addr       <= '0;
    end else if (rdy) begin
      instr_ready <= 1'b0;
      if (rob_clear) begin
        r_pc    <= rob_clear_pc;
        r_state <= w_pending ? S_DISCARD : S_FETCH;
        mem_req <= w_pending;
      end else begin
        case (r_state)
          S_FETCH:
            if (w_hit) begin
              instr_out      <= w_cdata;
              instr_addr_out <= r_pc;
              instr_ready    <= 1'b1;
              r_state        <= S_OFFER;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= word_align(r_pc);
              r_state  <= S_MEM_WAIT;
            end
          S_MEM_WAIT:
            if (w_fill) begin
              instr_out      <= mem_data;
              instr_addr_out <= r_pc;
              mem_req        <= 1'b0;
              instr_ready    <= 1'b1;
              r_state        <= S_OFFER;
            end
          S_OFFER: r_state <= S_WAIT_ISSUE;
          S_WAIT_ISSUE:
            if (instr_issued) begin
              r_pc    <= predict_pc;
              r_state <= S_FETCH;
            end else begin
              instr_ready <= 1'b1;
              r_state     <= S_OFFER;
            end
          S_DISCARD:
            if (mem_ready) begin
              mem_req <= 1'b0;
              r_state <= S_FETCH;
            end
          default: r_state <= S_FETCH;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fetcher.sv
// tb_fetcher: directed self-checking bench for fetcher with a latency-modelled memory and decoder.
module tb_fetcher;
  logic        clk, rst, rdy;
  logic        instr_ready, instr_issued, rob_clear, mem_req, mem_ready;
  logic [31:0] instr_out, instr_addr_out, predict_pc, rob_clear_pc, mem_addr, mem_data;
  int total = 0, bad = 0;
  int cyc = 0;
  int mem_lat = 3, lat = 0;
  bit pend = 0, prev_ready = 0;
  logic [31:0] cur_addr;
  int stall_left = 0;
  bit jump_set = 0, clr_with_issue = 0, clr_in_wait = 0;
  logic [31:0] jump_pc;
  logic [31:0] req_q[$], off_addr[$], off_data[$];
  int req_cyc[$], off_cyc[$];

  fetcher dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .instr_ready(instr_ready), .instr_out(instr_out), .instr_addr_out(instr_addr_out),
    .instr_issued(instr_issued), .predict_pc(predict_pc),
    .rob_clear(rob_clear), .rob_clear_pc(rob_clear_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running, wanted done");
    $fatal(1);
  end

  // memory controller and decoder models, both acting on the falling edge
  initial begin
    mem_ready = 0; instr_issued = 0; rob_clear = 0;
    mem_data = 0; predict_pc = 0; rob_clear_pc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      mem_ready = 0; instr_issued = 0; rob_clear = 0;
      if (rst) begin
        pend = 0; prev_ready = 0;
        req_q.delete(); req_cyc.delete(); off_addr.delete(); off_data.delete(); off_cyc.delete();
      end else if (rdy) begin
        if (pend) lat++;
        else if (mem_req) begin
          pend = 1; lat = 1; cur_addr = mem_addr;
          req_q.push_back(mem_addr); req_cyc.push_back(cyc);
          if (clr_in_wait) begin
            rob_clear = 1; rob_clear_pc = 32'h40; clr_in_wait = 0;
          end
        end
        if (pend && lat == mem_lat) begin
          mem_ready = 1; mem_data = word(cur_addr); pend = 0;
        end
        if (prev_ready) begin
          if (stall_left > 0) stall_left--;
          else begin
            instr_issued = 1;
            predict_pc = jump_set ? jump_pc : instr_addr_out + 32'd4;
            jump_set = 0;
            if (clr_with_issue) begin
              predict_pc = 32'h8; rob_clear = 1; rob_clear_pc = 32'h200; clr_with_issue = 0;
            end
          end
        end
        prev_ready = instr_ready;
        if (instr_ready) begin
          off_addr.push_back(instr_addr_out); off_data.push_back(instr_out); off_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic start(input bit hold_rdy);
    rst = 1; rdy = !hold_rdy;
    mem_lat = 3; stall_left = 0; jump_set = 0; clr_with_issue = 0; clr_in_wait = 0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; rdy = 1;
    #1;
    total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got %b want 0", instr_ready); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got %b want 0", mem_req); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got %h want 0", mem_addr); end
    total++; if (instr_out !== 32'h0) begin bad++; $display("FAIL reset_out got %h want 0", instr_out); end
    total++; if (instr_addr_out !== 32'h0) begin bad++; $display("FAIL reset_iaddr got %h want 0", instr_addr_out); end
    start(0);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL wait_req got %b want 1", mem_req); end
    total++; if (mem_addr === 32'h0) begin bad++; $display("FAIL pre_reset_addr got %h want nonzero", mem_addr); end
    rst = 1;
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL async_req got %b want 0", mem_req); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL async_addr got %h want 0", mem_addr); end
    total++; if (instr_out !== 32'h0 || instr_addr_out !== 32'h0) begin bad++; $display("FAIL async_out got %h/%h want 0/0", instr_out, instr_addr_out); end
    start(0);
    repeat (4) @(negedge clk);
    total++; if (req_q.size() < 1 || req_q[0] !== 32'h0) begin bad++; $display("FAIL post_reset_addr got n=%0d want first addr 0", req_q.size()); end
  endtask

  task automatic test_straight();
    start(0);
    repeat (24) @(negedge clk);
    total++; if (req_q.size() < 3 || off_addr.size() < 3) begin bad++; $display("FAIL straight_count got req=%0d off=%0d want >=3", req_q.size(), off_addr.size()); end
    else for (int i = 0; i < 3; i++) begin
      total++; if (req_q[i] !== 32'(4 * i)) begin bad++; $display("FAIL straight_req%0d got %h want %h", i, req_q[i], 4 * i); end
      total++; if (off_addr[i] !== 32'(4 * i)) begin bad++; $display("FAIL straight_iaddr%0d got %h want %h", i, off_addr[i], 4 * i); end
      total++; if (off_data[i] !== word(32'(4 * i))) begin bad++; $display("FAIL straight_data%0d got %h want %h", i, off_data[i], word(32'(4 * i))); end
    end
    total++; if (off_cyc.size() < 1 || req_cyc.size() < 1 || off_cyc[0] - req_cyc[0] != 3) begin bad++; $display("FAIL miss_latency got %0d want 3", off_cyc.size() ? off_cyc[0] - req_cyc[0] : -1); end
  endtask

  task automatic test_stall();
    int n0 = 0, r0 = 0;
    start(0);
    stall_left = 3;
    repeat (22) @(negedge clk);
    foreach (off_addr[i]) if (off_addr[i] == 32'h0) n0++;
    foreach (req_q[i]) if (req_q[i] == 32'h0) r0++;
    total++; if (n0 != 4) begin bad++; $display("FAIL stall_offers got %0d want 4", n0); end
    total++; if (r0 != 1) begin bad++; $display("FAIL stall_reqs got %0d want 1", r0); end
    if (off_cyc.size() >= 4)
      for (int i = 1; i < 4; i++) begin
        total++; if (off_cyc[i] - off_cyc[i-1] != 2 || off_data[i] !== word(32'h0)) begin bad++; $display("FAIL stall_retry%0d got gap=%0d data=%h want 2/%h", i, off_cyc[i] - off_cyc[i-1], off_data[i], word(32'h0)); end
      end
    total++; if (req_q.size() < 2 || req_q[1] !== 32'h4) begin bad++; $display("FAIL stall_next got n=%0d want addr 4", req_q.size()); end
  endtask

  task automatic test_jump();
    start(0);
    jump_set = 1; jump_pc = 32'h100;
    repeat (12) @(negedge clk);
    total++; if (req_q.size() < 2 || req_q[1] !== 32'h100) begin bad++; $display("FAIL jump_addr got %h want 00000100", req_q.size() > 1 ? req_q[1] : 32'hx); end
  endtask

  task automatic test_clear_issue();
    start(0);
    clr_with_issue = 1;
    repeat (12) @(negedge clk);
    total++; if (req_q.size() < 2 || req_q[1] !== 32'h200) begin bad++; $display("FAIL clear_issue got %h want 00000200", req_q.size() > 1 ? req_q[1] : 32'hx); end
  endtask

  task automatic test_clear_wait();
    start(0);
    clr_in_wait = 1;
    repeat (14) @(negedge clk);
    total++; if (req_q.size() < 2 || req_q[1] !== 32'h40) begin bad++; $display("FAIL clear_wait_addr got n=%0d want second addr 40", req_q.size()); end
    total++; if (off_addr.size() < 1 || off_addr[0] !== 32'h40 || off_data[0] !== word(32'h40)) begin bad++; $display("FAIL clear_wait_offer got n=%0d want first offer at 40", off_addr.size()); end
    total++; if (req_cyc.size() < 2 || req_cyc[1] - req_cyc[0] != 4) begin bad++; $display("FAIL clear_wait_gap got %0d want 4", req_cyc.size() > 1 ? req_cyc[1] - req_cyc[0] : -1); end
  endtask

  task automatic test_rdy();
    start(1);
    repeat (4) @(negedge clk);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rdy_hold got %b want 0", mem_req); end
    rdy = 1;
    @(negedge clk);
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rdy_release got %b want 1", mem_req); end
  endtask

`ifdef ICACHE_EN
  task automatic test_cache_hit();
    start(0);
    jump_set = 1; jump_pc = 32'h0;
    repeat (14) @(negedge clk);
    total++; if (off_addr.size() < 2 || off_addr[1] !== 32'h0 || off_data[1] !== word(32'h0)) begin bad++; $display("FAIL hit_offer got n=%0d want second offer at 0", off_addr.size()); end
    total++; if (off_cyc.size() < 2 || off_cyc[1] - off_cyc[0] != 3) begin bad++; $display("FAIL hit_gap got %0d want 3", off_cyc.size() > 1 ? off_cyc[1] - off_cyc[0] : -1); end
    total++; if (req_q.size() < 2 || req_q[1] !== 32'h4) begin bad++; $display("FAIL hit_noreq got n=%0d want second req at 4", req_q.size()); end
  endtask
`endif

  initial begin
    rst = 1; rdy = 1;
    test_reset();
    test_straight();
    test_stall();
    test_jump();
    test_clear_issue();
    test_clear_wait();
    test_rdy();
`ifdef ICACHE_EN
    test_cache_hit();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
